counter_bank: RTL and testbench
===============================

Name: counter_bank

Overview:
Parametrised successor to the single 8-bit loadable counter. It holds CHANNELS independent loadable counters of WIDTH bits, all sharing one programmable prescaler. Each channel has its own configuration: enable, direction and wrap/saturate mode. Each channel raises a terminal-count pulse. The block sits on the same simple write bus (wdata/wr) used by the existing counter, extended with a channel select and a config strobe.

Parameters:
WIDTH, 8, bit width of each counter and of wdata
CHANNELS, 4, number of counter channels (1..16)
SEL_W, 2, width of wsel; must satisfy 2**SEL_W >= CHANNELS; minimum 1
PRESCALE_W, 8, width of prescaler divider input

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset; clears all state immediately
wdata  in  WIDTH  load value for the selected counter
wr  in  1  load strobe; writes wdata into counter wsel
wsel  in  SEL_W  channel select for wr and cfg_wr
cfg_wr  in  1  config strobe; writes cfg_data into config of channel wsel
cfg_data  in  3  bit0 = en, bit1 = dir (0 = up, 1 = down), bit2 = sat (0 = wrap, 1 = saturate)
clr  in  1  synchronous clear of all counters
div  in  PRESCALE_W  prescaler divide value; one tick every div+1 clocks
data_cnt  out  CHANNELS*WIDTH  counter values, channel i at bits [i*WIDTH +: WIDTH]
tc  out  CHANNELS  per-channel terminal-count pulse
tick  out  1  prescaler tick, exported for observation

Behaviour:
- Reset (async, active-high), effective immediately and held while high:
  - all counts = 0, all cfg = 3'b000 (disabled, up, wrap)
  - prescaler count pcnt = 0, tick = 0, tc = 0
- Prescaler:
  - pcnt increments every clk. When pcnt >= div: tick = 1 that cycle (combinational from pcnt), and pcnt -> 0 at the edge.
  - div = 0 gives tick every cycle.
  - If div is lowered below the current pcnt, tick fires on the next cycle and pcnt restarts. No lockup.
  - Prescaler runs regardless of channel enables. clr does not affect it.
- Priority per channel, evaluated at each rising edge:
  - clr: count -> 0, tc = 0
  - else wr with wsel == i: count -> wdata, tc = 0
  - else a counting step if tick && en
  - else hold
- wsel >= CHANNELS: wr and cfg_wr are ignored and no state changes.
- cfg_wr and wr together on the same channel are both applied. The new cfg takes effect from the next edge and does not affect the current edge's step decision.
- Counting step, with MAX = 2**WIDTH-1 and terminal = MAX when up, 0 when down:
  - count != terminal: count +1 (up) or -1 (down); tc = 0
  - count == terminal, wrap: count -> 0 (up) or MAX (down); tc = 1
  - count == terminal, sat: count holds; tc = 1. tc therefore pulses on every tick while pinned.
- tc is registered. It is high for exactly one clk after the edge that performed the terminal step, and 0 in every cycle without such a step.
- data_cnt is driven directly from the count registers: a load or step is visible one cycle after the edge. No combinational path from inputs to data_cnt or tc.
- Width arithmetic: all counts are modulo 2**WIDTH, with no carry out beyond tc.
- Reset mid-count clears everything, including cfg. Channels must be re-enabled after reset.

Test Plan:
- Reset/default: assert reset for 4 time units mid-simulation, then wr ch0 = 8'h55 with cfg disabled -> data_cnt[7:0] = 8'h55 one cycle later and holds; all other channels 0; tc = 0.
- Up/wrap with div = 0: ch1 load 8'hFD, cfg = 3'b001 -> sequence FE, FF, 00, 01 on successive cycles; tc[1] = 1 only in the cycle after the FF->00 edge.
- Down/saturate with div = 3: ch2 load 8'h02, cfg = 3'b111 -> value changes every 4 clocks: 01, 00, then 00 held; tc[2] pulses once per tick while pinned at 00.
- Priority: ch3 counting up at div = 0, then assert clr and wr (ch3, 8'hAA) in the same cycle -> ch3 = 00. Next cycle wr alone -> ch3 = AA with no increment that edge; counting resumes with AB.
- Out-of-range select (CHANNELS = 3): wr and cfg_wr with wsel = 3 -> no channel changes.
- Prescaler shrink: div = 200, wait until pcnt ≈ 150, set div = 5 -> tick on the next cycle, then every 6 clocks.
- Async reset mid-operation: pulse reset between clock edges while channels are counting -> all outputs 0 immediately; counting does not resume until cfg is rewritten.

Source files
------------

// File: rtl/counter_bank_if.sv
// -----------------------------------------------------------------------------
// counter_bank_if
// Write bus and observation outputs of counter_bank.
//   master : bus driver (wdata, wr, wsel, cfg_wr, cfg_data, clr, div out;
//            data_cnt, tc, tick in)
//   slave  : counter_bank side (directions mirrored)
// -----------------------------------------------------------------------------
interface counter_bank_if #(
   parameter int WIDTH      = 8,
   parameter int CHANNELS   = 4,
   parameter int SEL_W      = 2,
   parameter int PRESCALE_W = 8
);
   logic [WIDTH-1:0]          wdata;
   logic                      wr;
   logic [SEL_W-1:0]          wsel;
   logic                      cfg_wr;
   logic [2:0]                cfg_data;
   logic                      clr;
   logic [PRESCALE_W-1:0]     div;
   logic [CHANNELS*WIDTH-1:0] data_cnt;
   logic [CHANNELS-1:0]       tc;
   logic                      tick;

   modport master (
      output wdata, wr, wsel, cfg_wr, cfg_data, clr, div,
      input  data_cnt, tc, tick
   );

   modport slave (
      input  wdata, wr, wsel, cfg_wr, cfg_data, clr, div,
      output data_cnt, tc, tick
   );
endinterface

// File: rtl/counter_bank.sv
// -----------------------------------------------------------------------------
// counter_bank
// CHANNELS independent loadable WIDTH-bit counters sharing one programmable
// prescaler. Each channel has its own enable / direction / wrap-or-saturate
// config and a registered terminal-count pulse.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, clears counts, configs, prescaler
//   bus   : counter_bank_if.slave
//           wdata/wr/wsel  load the selected counter
//           cfg_wr/cfg_data write {sat, dir, en} of the selected channel
//           clr            synchronous clear of all counters
//           div            prescaler divide, one tick every div+1 clocks
//           data_cnt       packed counter values, channel i at [i*WIDTH +: WIDTH]
//           tc             per-channel terminal-count pulse
//           tick           prescaler tick
// -----------------------------------------------------------------------------

// One counter channel: count register, config register and tc flag.
module counter_bank_lane #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] wdata,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_data,
   input  logic             tick,
   output logic [WIDTH-1:0] count,
   output logic             tc
);
   typedef struct packed {
      logic sat;   // 1 = saturate at terminal, 0 = wrap
      logic dir;   // 1 = down, 0 = up
      logic en;
   } cfg_t;

   localparam logic [WIDTH-1:0] MAX = '1;

   cfg_t             cfg;
   logic [WIDTH-1:0] term;

   assign term = cfg.dir ? '0 : MAX;

   // The step decision uses the config held before this edge, so a config
   // write lands together with (not ahead of) a same-cycle load or step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         cfg   <= '0;
         tc    <= 1'b0;
      end else begin
         if (cfg_we) cfg <= cfg_t'(cfg_data);
         tc <= 1'b0;
         if (clr) begin
            count <= '0;
         end else if (ld) begin
            count <= wdata;
         end else if (tick && cfg.en) begin
            if (count != term) begin
               count <= cfg.dir ? count - WIDTH'(1) : count + WIDTH'(1);
            end else begin
               // Terminal step: pulse tc; saturating channels stay pinned
               // and therefore pulse again on every following tick.
               tc <= 1'b1;
               if (!cfg.sat) count <= cfg.dir ? MAX : '0;
            end
         end
      end
   end
endmodule

module counter_bank #(
   parameter int WIDTH      = 8,
   parameter int CHANNELS   = 4,
   parameter int SEL_W      = 2,
   parameter int PRESCALE_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   counter_bank_if.slave  bus
);
   logic [PRESCALE_W-1:0]           pcnt;
   logic                            tick;
   logic [CHANNELS-1:0][WIDTH-1:0]  cnt;
   logic [CHANNELS-1:0]             tc_v;

   // Compare with >= so lowering div below the running count fires at once
   // and restarts instead of waiting for a wrap. Masked during reset so the
   // exported tick reads 0 while reset is held.
   assign tick = ~reset & (pcnt >= bus.div);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pcnt <= '0;
      else       pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
   end

   // A wsel value at or beyond CHANNELS matches no lane, so such writes drop.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      logic sel;
      assign sel = (bus.wsel == SEL_W'(i));

      counter_bank_lane #(.WIDTH(WIDTH)) u_lane (
         .clk      (clk),
         .reset    (reset),
         .clr      (bus.clr),
         .ld       (bus.wr & sel),
         .wdata    (bus.wdata),
         .cfg_we   (bus.cfg_wr & sel),
         .cfg_data (bus.cfg_data),
         .tick     (tick),
         .count    (cnt[i]),
         .tc       (tc_v[i])
      );
   end

   assign bus.data_cnt = cnt;
   assign bus.tc       = tc_v;
   assign bus.tick     = tick;
endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;
   logic clk;
   logic reset;
   int   cyc   = 0;
   int   nvec  = 0;
   int   nmis  = 0;

   counter_bank_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .PRESCALE_W(8)) b4 ();
   counter_bank_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .PRESCALE_W(8)) b3 ();

   counter_bank #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .PRESCALE_W(8)) dut4 (
      .clk(clk), .reset(reset), .bus(b4.slave));
   counter_bank #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .PRESCALE_W(8)) dut3 (
      .clk(clk), .reset(reset), .bus(b3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 = count of channel ch, 1 = whole tc vector, 2 = tick
   typedef struct {
      int    cyc;
      int    d;
      int    kind;
      int    ch;
      int    val;
      string nm;
   } exp_t;
   exp_t sq[$];

   task automatic expect_at(input int dc, input int d, input int kind,
                            input int ch, input int val, input string nm);
      exp_t e;
      e.cyc = cyc + dc; e.d = d; e.kind = kind; e.ch = ch; e.val = val; e.nm = nm;
      sq.push_back(e);
   endtask

   function automatic int f_act(input exp_t e);
      case (e.kind)
         0:       return (e.d == 0) ? int'(b4.data_cnt[e.ch*8 +: 8]) : int'(b3.data_cnt[e.ch*8 +: 8]);
         1:       return (e.d == 0) ? int'(b4.tc) : int'(b3.tc);
         default: return (e.d == 0) ? int'(b4.tick) : int'(b3.tick);
      endcase
   endfunction

   // Monitor: at each falling edge, check every expectation due this cycle.
   always @(negedge clk) begin
      for (int i = sq.size() - 1; i >= 0; i--) begin
         if (sq[i].cyc <= cyc) begin
            nvec++;
            if (sq[i].cyc < cyc || f_act(sq[i]) != sq[i].val) begin
               nmis++;
               $display("FAIL %s (dut%0d ch%0d cyc %0d): got %0h, expected %0h",
                        sq[i].nm, sq[i].d, sq[i].ch, sq[i].cyc, f_act(sq[i]), sq[i].val);
            end
            sq.delete(i);
         end
      end
   end

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic run(input int n);
      repeat (n) nxt();
   endtask

   task automatic idle();
      b4.wr = 1'b0; b4.cfg_wr = 1'b0; b4.clr = 1'b0;
      b3.wr = 1'b0; b3.cfg_wr = 1'b0; b3.clr = 1'b0;
   endtask

   task automatic wr4(input int ch, input logic [7:0] v);
      b4.wr = 1'b1; b4.wsel = 2'(ch); b4.wdata = v;
   endtask

   task automatic cfg4(input int ch, input logic [2:0] c);
      b4.cfg_wr = 1'b1; b4.wsel = 2'(ch); b4.cfg_data = c;
   endtask

   task automatic all_zero(input int dc, input string nm);
      for (int ch = 0; ch < 4; ch++) expect_at(dc, 0, 0, ch, 0, nm);
      for (int ch = 0; ch < 3; ch++) expect_at(dc, 1, 0, ch, 0, nm);
      expect_at(dc, 0, 1, 0, 0, {nm, "_tc"});
      expect_at(dc, 0, 2, 0, 0, {nm, "_tick"});
      expect_at(dc, 1, 2, 0, 0, {nm, "_tick3"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      b4.wdata = '0; b4.wsel = '0; b4.cfg_data = '0; b4.div = '0;
      b3.wdata = '0; b3.wsel = '0; b3.cfg_data = '0; b3.div = '0;
      idle();
      run(2);
      all_zero(0, "reset_state");
      nxt();
      reset = 1'b0;

      // Out-of-range select on the 3-channel instance
      b3.wr = 1'b1; b3.wsel = 2'd0; b3.wdata = 8'h11; nxt();
      b3.wsel = 2'd2; b3.wdata = 8'h77; nxt();
      b3.wsel = 2'd3; b3.wdata = 8'hEE; b3.cfg_wr = 1'b1; b3.cfg_data = 3'b001; nxt();
      idle();
      expect_at(0, 1, 0, 0, 8'h11, "oor_ch0");
      expect_at(0, 1, 0, 1, 8'h00, "oor_ch1");
      expect_at(0, 1, 0, 2, 8'h77, "oor_ch2");
      expect_at(3, 1, 0, 0, 8'h11, "oor_ch0_hold");
      expect_at(3, 1, 0, 1, 8'h00, "oor_ch1_hold");
      expect_at(3, 1, 0, 2, 8'h77, "oor_ch2_hold");
      expect_at(3, 1, 1, 0, 0, "oor_tc");
      run(3);

      // Reset mid-simulation, then load of a disabled channel
      wr4(1, 8'h33); nxt(); idle();
      expect_at(0, 0, 0, 1, 8'h33, "pre_reset_ch1");
      nxt();
      all_zero(0, "reset_pulse");
      #1 reset = 1'b1;
      #4 reset = 1'b0;
      wr4(0, 8'h55);
      expect_at(1, 0, 0, 0, 8'h55, "load_ch0");
      for (int ch = 1; ch < 4; ch++) expect_at(1, 0, 0, ch, 0, "load_others");
      expect_at(1, 0, 1, 0, 0, "load_tc");
      expect_at(3, 0, 0, 0, 8'h55, "load_ch0_hold");
      expect_at(3, 0, 1, 0, 0, "load_tc_hold");
      nxt(); idle(); run(2);

      // Up / wrap, div = 0, channel 1
      wr4(1, 8'hFD); cfg4(1, 3'b001);
      expect_at(1, 0, 0, 1, 8'hFD, "upwrap_FD");
      expect_at(2, 0, 0, 1, 8'hFE, "upwrap_FE");
      expect_at(3, 0, 0, 1, 8'hFF, "upwrap_FF");
      expect_at(4, 0, 0, 1, 8'h00, "upwrap_00");
      expect_at(5, 0, 0, 1, 8'h01, "upwrap_01");
      expect_at(6, 0, 0, 1, 8'h01, "upwrap_disabled");
      expect_at(3, 0, 1, 0, 4'b0000, "upwrap_tc_pre");
      expect_at(4, 0, 1, 0, 4'b0010, "upwrap_tc");
      expect_at(5, 0, 1, 0, 4'b0000, "upwrap_tc_post");
      nxt(); idle(); run(3);
      cfg4(1, 3'b000); nxt(); idle(); nxt();

      // Down / saturate, div = 3, channel 2
      b4.div = 8'd3; wr4(2, 8'h02); cfg4(2, 3'b111);
      expect_at(1, 0, 0, 2, 8'h02, "dsat_02");
      expect_at(3, 0, 0, 2, 8'h02, "dsat_02_hold");
      expect_at(2, 0, 2, 0, 0, "dsat_tick_lo");
      expect_at(3, 0, 2, 0, 1, "dsat_tick_hi");
      expect_at(4, 0, 0, 2, 8'h01, "dsat_01");
      expect_at(7, 0, 0, 2, 8'h01, "dsat_01_hold");
      expect_at(8, 0, 0, 2, 8'h00, "dsat_00");
      expect_at(8, 0, 1, 0, 4'b0000, "dsat_tc_reach");
      expect_at(11, 0, 1, 0, 4'b0000, "dsat_tc_gap");
      expect_at(12, 0, 0, 2, 8'h00, "dsat_pinned");
      expect_at(12, 0, 1, 0, 4'b0100, "dsat_tc1");
      expect_at(13, 0, 1, 0, 4'b0000, "dsat_tc1_end");
      expect_at(16, 0, 1, 0, 4'b0100, "dsat_tc2");
      expect_at(17, 0, 1, 0, 4'b0000, "dsat_tc2_end");
      expect_at(17, 0, 0, 2, 8'h00, "dsat_pinned2");
      nxt(); idle(); run(16);
      cfg4(2, 3'b000); nxt(); idle();
      b4.div = 8'd0;

      // Priority: clr beats wr; wr beats step
      wr4(3, 8'h10); cfg4(3, 3'b001);
      expect_at(1, 0, 0, 3, 8'h10, "prio_load");
      expect_at(2, 0, 0, 3, 8'h11, "prio_count");
      expect_at(3, 0, 0, 3, 8'h00, "prio_clr_ch3");
      expect_at(3, 0, 0, 0, 8'h00, "prio_clr_ch0");
      expect_at(3, 0, 0, 1, 8'h00, "prio_clr_ch1");
      expect_at(3, 0, 1, 0, 4'b0000, "prio_clr_tc");
      expect_at(4, 0, 0, 3, 8'hAA, "prio_wr");
      expect_at(5, 0, 0, 3, 8'hAB, "prio_AB");
      expect_at(6, 0, 0, 3, 8'hAC, "prio_AC");
      nxt(); idle(); nxt();
      b4.clr = 1'b1; wr4(3, 8'hAA); nxt();
      b4.clr = 1'b0; nxt(); idle(); run(2);

      // Prescaler shrink: div 200 -> 5 with pcnt at 150
      b4.div = 8'd200;
      expect_at(100, 0, 0, 3, 8'hAC, "shrink_hold");
      expect_at(149, 0, 2, 0, 0, "shrink_tick_149");
      expect_at(150, 0, 2, 0, 1, "shrink_tick_now");
      expect_at(151, 0, 2, 0, 0, "shrink_tick_151");
      expect_at(151, 0, 0, 3, 8'hAD, "shrink_AD");
      expect_at(155, 0, 2, 0, 0, "shrink_tick_155");
      expect_at(156, 0, 2, 0, 1, "shrink_tick_156");
      expect_at(156, 0, 0, 3, 8'hAD, "shrink_AD_hold");
      expect_at(157, 0, 0, 3, 8'hAE, "shrink_AE");
      expect_at(162, 0, 2, 0, 1, "shrink_tick_162");
      expect_at(163, 0, 0, 3, 8'hAF, "shrink_AF");
      run(150);
      b4.div = 8'd5;
      run(13);
      b4.div = 8'd0;

      // Async reset pulse between edges while counting
      expect_at(1, 0, 0, 3, 8'hB0, "async_pre");
      run(2);
      all_zero(0, "async_reset");
      expect_at(1, 0, 0, 3, 8'h00, "async_no_resume1");
      expect_at(1, 0, 2, 0, 1, "async_prescaler_runs");
      expect_at(2, 0, 0, 3, 8'h00, "async_no_resume2");
      expect_at(3, 0, 0, 3, 8'h00, "async_cfg_edge");
      expect_at(4, 0, 0, 3, 8'h01, "async_resume");
      #2 reset = 1'b1;
      #4 reset = 1'b0;
      run(2);
      cfg4(3, 3'b001); nxt(); idle(); run(3);

      if (sq.size() != 0) begin
         nvec += sq.size();
         nmis += sq.size();
         $display("FAIL pending_expectations: got %0d unchecked, expected 0", sq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
